// File: rtl/current_loop_sequencer.sv
// rtl/current_loop_sequencer.sv - 20 kHz current-loop sequencer: tick, ADC/PI/PWM strobes, soft-start and trips
//
// Purpose:
//   Divides clk down to the loop tick. On each tick in RUN it requests an ADC
//   conversion, latches the sample, steps the PI controller and then loads
//   the PWM reference. Kp/Ki/VMAX are applied only on tick boundaries. VMAX
//   soft-starts from zero. Overcurrent, ADC timeout and persistent
//   saturation all trip the loop into FAULT.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   run_req, fault_clr        run request level, fault clear level (only with run_req=0)
//   cfg_update                pulse; captures Kp_in/Ki_in/VMAX_in into pending registers
//   Kp_in, Ki_in, VMAX_in     gain (Q8.8) and voltage limit (Q1.15) inputs
//   adc_start, adc_done       conversion request strobe and completion strobe
//   adc_current               signed sample, valid with adc_done
//   actual_current            latched sample fed to the PI controller
//   pi_enable, pi_reset_n     PI step strobe, PI reset (held low outside RUN)
//   sat_flag                  PI saturation indicator
//   Kp_out, Ki_out, vmax_out  applied gains and ramped voltage limit
//   pwm_load                  PWM reference load strobe
//   state, fault_code         0=IDLE 1=RUN 2=FAULT; 0=none 1=overcurrent 2=ADC timeout 3=saturation

module current_loop_sequencer #(
    parameter int TICK_DIV        = 5000,
    parameter int ADC_TIMEOUT     = 200,
    parameter int OC_LIMIT        = 12000,
    parameter int SAT_FAULT_TICKS = 2000,
    parameter int RAMP_STEP       = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run_req,
    input  logic               fault_clr,
    input  logic               cfg_update,
    input  logic [15:0]        Kp_in,
    input  logic [15:0]        Ki_in,
    input  logic [15:0]        VMAX_in,
    output logic               adc_start,
    input  logic               adc_done,
    input  logic signed [31:0] adc_current,
    output logic signed [31:0] actual_current,
    output logic               pi_enable,
    output logic               pi_reset_n,
    input  logic               sat_flag,
    output logic [15:0]        Kp_out,
    output logic [15:0]        Ki_out,
    output logic [15:0]        vmax_out,
    output logic               pwm_load,
    output logic [1:0]         state,
    output logic [1:0]         fault_code
);

    localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WAIT_W = $clog2(ADC_TIMEOUT + 1);
    localparam int SAT_W  = $clog2(SAT_FAULT_TICKS + 1);

    localparam logic [1:0] FC_NONE = 2'd0;
    localparam logic [1:0] FC_OC   = 2'd1;
    localparam logic [1:0] FC_ADC  = 2'd2;
    localparam logic [1:0] FC_SAT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    // Position inside one tick's ADC -> PI -> PWM sequence. Anything other
    // than PH_NONE counts as "in flight" and defers a RUN->IDLE exit.
    typedef enum logic [1:0] {
        PH_NONE = 2'd0,
        PH_WAIT = 2'd1,
        PH_PI   = 2'd2,
        PH_LOAD = 2'd3
    } phase_e;

    state_e              state_q;
    phase_e              phase_q;
    logic [DIV_W-1:0]    div_q;
    logic [DIV_W-1:0]    div_d;
    logic [WAIT_W-1:0]   wait_q;
    logic [SAT_W-1:0]    sat_cnt_q;
    logic [15:0]         pend_kp_q;
    logic [15:0]         pend_ki_q;
    logic [15:0]         pend_vmax_q;
    logic [15:0]         vmax_app_q;
    logic [15:0]         kp_out_q;
    logic [15:0]         ki_out_q;
    logic [15:0]         vmax_out_q;
    logic signed [31:0]  actual_current_q;
    logic                adc_start_q;
    logic                pi_enable_q;
    logic                pwm_load_q;
    logic                pi_reset_n_q;
    logic [1:0]          fault_code_q;

    logic                tick;
    logic [32:0]         adc_abs;
    logic                oc_trip;
    logic [16:0]         ramp_sum;
    logic [15:0]         ramp_sat;
    logic [15:0]         ramp_next;

    assign tick  = (div_q == DIV_W'(TICK_DIV - 1));
    assign div_d = tick ? '0 : div_q + 1'b1;

    // Magnitude in 33 bits so that -2^31 becomes +2^31 and trips cleanly.
    assign adc_abs = adc_current[31] ? (33'd0 - {adc_current[31], adc_current})
                                     : {1'b0, adc_current};
    assign oc_trip = (adc_abs > 33'(OC_LIMIT));

    // Soft-start: saturating add, then never above the applied limit. The
    // same min() also pulls vmax_out down when the applied limit is lowered.
    assign ramp_sum  = {1'b0, vmax_out_q} + 17'(RAMP_STEP);
    assign ramp_sat  = (ramp_sum > 17'h07FFF) ? 16'h7FFF : ramp_sum[15:0];
    assign ramp_next = (ramp_sat > vmax_app_q) ? vmax_app_q : ramp_sat;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            phase_q          <= PH_NONE;
            div_q            <= '0;
            wait_q           <= '0;
            sat_cnt_q        <= '0;
            pend_kp_q        <= '0;
            pend_ki_q        <= '0;
            pend_vmax_q      <= '0;
            vmax_app_q       <= '0;
            kp_out_q         <= '0;
            ki_out_q         <= '0;
            vmax_out_q       <= '0;
            actual_current_q <= '0;
            adc_start_q      <= 1'b0;
            pi_enable_q      <= 1'b0;
            pwm_load_q       <= 1'b0;
            pi_reset_n_q     <= 1'b0;
            fault_code_q     <= FC_NONE;
        end else begin
            div_q       <= div_d;
            adc_start_q <= 1'b0;
            pi_enable_q <= 1'b0;
            pwm_load_q  <= 1'b0;

            if (cfg_update) begin
                pend_kp_q   <= Kp_in;
                pend_ki_q   <= Ki_in;
                pend_vmax_q <= VMAX_in;
            end

            // Reads the old pending values, so a cfg_update on the tick
            // cycle only takes effect at the following tick.
            if (tick) begin
                kp_out_q   <= pend_kp_q;
                ki_out_q   <= pend_ki_q;
                vmax_app_q <= pend_vmax_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (tick && run_req) begin
                        state_q      <= ST_RUN;
                        phase_q      <= PH_WAIT;
                        pi_reset_n_q <= 1'b1;
                        adc_start_q  <= 1'b1;
                        wait_q       <= '0;
                        sat_cnt_q    <= '0;
                        vmax_out_q   <= '0;
                    end
                end

                ST_RUN: begin
                    case (phase_q)
                        PH_WAIT: begin
                            if (adc_done) begin
                                actual_current_q <= adc_current;
                                if (oc_trip) begin
                                    state_q      <= ST_FAULT;
                                    phase_q      <= PH_NONE;
                                    fault_code_q <= FC_OC;
                                    pi_reset_n_q <= 1'b0;
                                    vmax_out_q   <= '0;
                                end else begin
                                    pi_enable_q <= 1'b1;
                                    phase_q     <= PH_PI;
                                end
                            end else if (wait_q == WAIT_W'(ADC_TIMEOUT - 1)) begin
                                state_q      <= ST_FAULT;
                                phase_q      <= PH_NONE;
                                fault_code_q <= FC_ADC;
                                pi_reset_n_q <= 1'b0;
                                vmax_out_q   <= '0;
                            end else begin
                                wait_q <= wait_q + 1'b1;
                            end
                        end

                        PH_PI: begin
                            pwm_load_q <= 1'b1;
                            vmax_out_q <= ramp_next;
                            phase_q    <= PH_LOAD;
                        end

                        PH_LOAD: begin
                            phase_q <= PH_NONE;
                            if (!sat_flag) begin
                                sat_cnt_q <= '0;
                            end else if (sat_cnt_q == SAT_W'(SAT_FAULT_TICKS - 1)) begin
                                state_q      <= ST_FAULT;
                                fault_code_q <= FC_SAT;
                                pi_reset_n_q <= 1'b0;
                                vmax_out_q   <= '0;
                            end else begin
                                sat_cnt_q <= sat_cnt_q + 1'b1;
                            end
                        end

                        default: begin
                            if (tick) begin
                                if (run_req) begin
                                    phase_q     <= PH_WAIT;
                                    adc_start_q <= 1'b1;
                                    wait_q      <= '0;
                                end else begin
                                    state_q      <= ST_IDLE;
                                    pi_reset_n_q <= 1'b0;
                                    vmax_out_q   <= '0;
                                end
                            end
                        end
                    endcase
                end

                default: begin
                    if (fault_clr && !run_req) begin
                        state_q      <= ST_IDLE;
                        fault_code_q <= FC_NONE;
                    end
                end
            endcase
        end
    end

    assign adc_start      = adc_start_q;
    assign pi_enable      = pi_enable_q;
    assign pwm_load       = pwm_load_q;
    assign pi_reset_n     = pi_reset_n_q;
    assign actual_current = actual_current_q;
    assign Kp_out         = kp_out_q;
    assign Ki_out         = ki_out_q;
    assign vmax_out       = vmax_out_q;
    assign state          = state_q;
    assign fault_code     = fault_code_q;

endmodule

// File: tb/tb_current_loop_sequencer.sv
// tb/tb_current_loop_sequencer.sv - directed self-checking bench for current_loop_sequencer

module tb_current_loop_sequencer;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               run_req;
    logic               fault_clr;
    logic               cfg_update;
    logic [15:0]        Kp_in;
    logic [15:0]        Ki_in;
    logic [15:0]        VMAX_in;
    logic               adc_start;
    logic               adc_done;
    logic signed [31:0] adc_current;
    logic signed [31:0] actual_current;
    logic               pi_enable;
    logic               pi_reset_n;
    logic               sat_flag;
    logic [15:0]        Kp_out;
    logic [15:0]        Ki_out;
    logic [15:0]        vmax_out;
    logic               pwm_load;
    logic [1:0]         state;
    logic [1:0]         fault_code;

    int checks = 0;
    int fails  = 0;

    current_loop_sequencer #(
        .TICK_DIV       (100),
        .ADC_TIMEOUT    (20),
        .OC_LIMIT       (12000),
        .SAT_FAULT_TICKS(3),
        .RAMP_STEP      (16)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .run_req       (run_req),
        .fault_clr     (fault_clr),
        .cfg_update    (cfg_update),
        .Kp_in         (Kp_in),
        .Ki_in         (Ki_in),
        .VMAX_in       (VMAX_in),
        .adc_start     (adc_start),
        .adc_done      (adc_done),
        .adc_current   (adc_current),
        .actual_current(actual_current),
        .pi_enable     (pi_enable),
        .pi_reset_n    (pi_reset_n),
        .sat_flag      (sat_flag),
        .Kp_out        (Kp_out),
        .Ki_out        (Ki_out),
        .vmax_out      (vmax_out),
        .pwm_load      (pwm_load),
        .state         (state),
        .fault_code    (fault_code)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of cycles until adc_start is seen, or -1.
    task automatic wait_start(output int n);
        n = -1;
        for (int i = 1; i <= 300; i++) begin
            cyc();
            if (adc_start === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // From the adc_start cycle, answer dly cycles later with val.
    task automatic do_seq(input int dly, input logic signed [31:0] val);
        repeat (dly) cyc();
        adc_current = val;
        adc_done    = 1'b1;
        cyc();
        adc_done    = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; run_req = 1'b0; fault_clr = 1'b0; cfg_update = 1'b0;
        Kp_in = '0; Ki_in = '0; VMAX_in = '0;
        adc_done = 1'b0; adc_current = '0; sat_flag = 1'b0;
        repeat (2) cyc();
        checks++;
        if ({adc_start, pi_enable, pwm_load} !== 3'b000) begin
            fails++; $display("FAIL reset_strobes: got %b expected 000", {adc_start, pi_enable, pwm_load});
        end
        checks++;
        if (pi_reset_n !== 1'b0) begin
            fails++; $display("FAIL reset_pi_reset_n: got %b expected 0", pi_reset_n);
        end
        checks++;
        if (state !== 2'd0 || fault_code !== 2'd0) begin
            fails++; $display("FAIL reset_state: got %0d/%0d expected 0/0", state, fault_code);
        end
        checks++;
        if (actual_current !== 32'sd0 || Kp_out !== 16'd0 || Ki_out !== 16'd0 || vmax_out !== 16'd0) begin
            fails++; $display("FAIL reset_data: got %0d %h %h %h expected zeros", actual_current, Kp_out, Ki_out, vmax_out);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_run();
        int n;
        logic [15:0] exp_v [4];
        exp_v[0] = 16'd16; exp_v[1] = 16'd32; exp_v[2] = 16'd40; exp_v[3] = 16'd40;
        Kp_in = 16'h0180; Ki_in = 16'h0020; VMAX_in = 16'd40;
        cfg_update = 1'b1;
        cyc();
        cfg_update = 1'b0;
        run_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_start(n);
            checks++;
            if (n < 0) begin
                fails++; $display("FAIL run_adc_start_%0d: no adc_start within 300 cycles", k);
            end
            if (k == 0) begin
                checks++;
                if (state !== 2'd1 || pi_reset_n !== 1'b1 || vmax_out !== 16'd0) begin
                    fails++; $display("FAIL run_entry: got state %0d pi_reset_n %b vmax %0d expected 1 1 0", state, pi_reset_n, vmax_out);
                end
                checks++;
                if (Kp_out !== 16'h0180 || Ki_out !== 16'h0020) begin
                    fails++; $display("FAIL run_gains: got %h %h expected 0180 0020", Kp_out, Ki_out);
                end
            end else begin
                checks++;
                if (n !== 93) begin
                    fails++; $display("FAIL run_tick_period_%0d: got %0d expected 93 cycles after pwm_load", k, n);
                end
            end
            do_seq(5, 500);
            checks++;
            if (pi_enable !== 1'b1 || pwm_load !== 1'b0 || actual_current !== 32'sd500) begin
                fails++; $display("FAIL run_pi_step_%0d: got pi_enable %b pwm_load %b current %0d expected 1 0 500", k, pi_enable, pwm_load, actual_current);
            end
            cyc();
            checks++;
            if (pi_enable !== 1'b0 || pwm_load !== 1'b1) begin
                fails++; $display("FAIL run_pwm_load_%0d: got pi_enable %b pwm_load %b expected 0 1", k, pi_enable, pwm_load);
            end
            checks++;
            if (vmax_out !== exp_v[k]) begin
                fails++; $display("FAIL run_ramp_%0d: got %0d expected %0d", k, vmax_out, exp_v[k]);
            end
        end

        VMAX_in = 16'd20;
        cfg_update = 1'b1;
        cyc();
        cfg_update = 1'b0;
        wait_start(n);
        do_seq(5, 500);
        cyc();
        checks++;
        if (pwm_load !== 1'b1 || vmax_out !== 16'd20) begin
            fails++; $display("FAIL run_vmax_clamp: got pwm_load %b vmax %0d expected 1 20", pwm_load, vmax_out);
        end

        // cfg_update on the tick cycle: old pending applies now, new one next tick.
        repeat (92) cyc();
        Kp_in = 16'h0300;
        cfg_update = 1'b1;
        cyc();
        cfg_update = 1'b0;
        checks++;
        if (adc_start !== 1'b1 || Kp_out !== 16'h0180) begin
            fails++; $display("FAIL cfg_on_tick_old: got adc_start %b Kp %h expected 1 0180", adc_start, Kp_out);
        end
        do_seq(5, 500);
        cyc();
        wait_start(n);
        checks++;
        if (n < 0 || Kp_out !== 16'h0300) begin
            fails++; $display("FAIL cfg_on_tick_new: got n %0d Kp %h expected Kp 0300", n, Kp_out);
        end
        do_seq(5, 500);
        cyc();
    endtask

    task automatic test_stop();
        int cnt = 0;
        run_req = 1'b0;
        for (int i = 0; i < 150; i++) begin
            cyc();
            if (adc_start === 1'b1) cnt++;
        end
        checks++;
        if (cnt !== 0 || state !== 2'd0 || pi_reset_n !== 1'b0 || vmax_out !== 16'd0) begin
            fails++; $display("FAIL stop_to_idle: got starts %0d state %0d pi_reset_n %b vmax %0d expected 0 0 0 0", cnt, state, pi_reset_n, vmax_out);
        end
    endtask

    task automatic test_overcurrent();
        int n;
        run_req = 1'b1;
        wait_start(n);
        do_seq(3, 12000);
        checks++;
        if (pi_enable !== 1'b1 || state !== 2'd1) begin
            fails++; $display("FAIL oc_at_limit: got pi_enable %b state %0d expected 1 1", pi_enable, state);
        end
        cyc();
        wait_start(n);
        do_seq(3, -12001);
        checks++;
        if (state !== 2'd2 || fault_code !== 2'd1) begin
            fails++; $display("FAIL oc_trip: got state %0d code %0d expected 2 1", state, fault_code);
        end
        checks++;
        if (pi_enable !== 1'b0 || pi_reset_n !== 1'b0 || actual_current !== -32'sd12001) begin
            fails++; $display("FAIL oc_outputs: got pi_enable %b pi_reset_n %b current %0d expected 0 0 -12001", pi_enable, pi_reset_n, actual_current);
        end
        cyc();
        checks++;
        if (pi_enable !== 1'b0 || pwm_load !== 1'b0) begin
            fails++; $display("FAIL oc_no_step: got pi_enable %b pwm_load %b expected 0 0", pi_enable, pwm_load);
        end
        fault_clr = 1'b1;
        repeat (3) cyc();
        checks++;
        if (state !== 2'd2 || fault_code !== 2'd1) begin
            fails++; $display("FAIL oc_clr_ignored: got state %0d code %0d expected 2 1", state, fault_code);
        end
        run_req = 1'b0;
        cyc();
        checks++;
        if (state !== 2'd0 || fault_code !== 2'd0) begin
            fails++; $display("FAIL oc_clr: got state %0d code %0d expected 0 0", state, fault_code);
        end
        fault_clr = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        run_req = 1'b1;
        wait_start(n);
        repeat (19) cyc();
        checks++;
        if (state !== 2'd1) begin
            fails++; $display("FAIL to_early: got state %0d expected 1 at 19 cycles", state);
        end
        cyc();
        checks++;
        if (state !== 2'd2 || fault_code !== 2'd2 || pi_reset_n !== 1'b0) begin
            fails++; $display("FAIL to_trip: got state %0d code %0d pi_reset_n %b expected 2 2 0", state, fault_code, pi_reset_n);
        end
        adc_current = 32'sd777;
        adc_done = 1'b1;
        cyc();
        adc_done = 1'b0;
        checks++;
        if (actual_current !== -32'sd12001 || pi_enable !== 1'b0) begin
            fails++; $display("FAIL to_late_done: got current %0d pi_enable %b expected -12001 0", actual_current, pi_enable);
        end
        cyc();
        checks++;
        if (pwm_load !== 1'b0 || state !== 2'd2) begin
            fails++; $display("FAIL to_late_state: got pwm_load %b state %0d expected 0 2", pwm_load, state);
        end
        run_req = 1'b0;
        fault_clr = 1'b1;
        cyc();
        fault_clr = 1'b0;
        checks++;
        if (state !== 2'd0 || fault_code !== 2'd0) begin
            fails++; $display("FAIL to_clr: got state %0d code %0d expected 0 0", state, fault_code);
        end
    endtask

    task automatic test_saturation();
        int n;
        logic pat [6];
        pat[0] = 1'b1; pat[1] = 1'b1; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b1; pat[5] = 1'b1;
        run_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_start(n);
            do_seq(2, 100);
            cyc();
            checks++;
            if (pwm_load !== 1'b1) begin
                fails++; $display("FAIL sat_pwm_load_%0d: got %b expected 1", k, pwm_load);
            end
            sat_flag = pat[k];
            cyc();
            sat_flag = 1'b0;
            checks++;
            if (k < 5) begin
                if (state !== 2'd1 || fault_code !== 2'd0) begin
                    fails++; $display("FAIL sat_no_fault_%0d: got state %0d code %0d expected 1 0", k, state, fault_code);
                end
            end else begin
                if (state !== 2'd2 || fault_code !== 2'd3) begin
                    fails++; $display("FAIL sat_fault: got state %0d code %0d expected 2 3", state, fault_code);
                end
            end
        end
        run_req = 1'b0;
        fault_clr = 1'b1;
        cyc();
        fault_clr = 1'b0;
    endtask

    task automatic test_async_reset();
        int n;
        run_req = 1'b1;
        wait_start(n);
        repeat (2) cyc();
        reset_n = 1'b0;
        #2;
        checks++;
        if ({adc_start, pi_enable, pwm_load, pi_reset_n} !== 4'b0000 || state !== 2'd0) begin
            fails++; $display("FAIL areset_ctrl: got strobes %b state %0d expected 0000 0", {adc_start, pi_enable, pwm_load, pi_reset_n}, state);
        end
        checks++;
        if (Kp_out !== 16'd0 || actual_current !== 32'sd0 || vmax_out !== 16'd0 || fault_code !== 2'd0) begin
            fails++; $display("FAIL areset_data: got Kp %h current %0d vmax %0d code %0d expected zeros", Kp_out, actual_current, vmax_out, fault_code);
        end
        cyc();
        reset_n = 1'b1;
        wait_start(n);
        checks++;
        if (n !== 100) begin
            fails++; $display("FAIL areset_first_start: got %0d cycles expected 100", n);
        end
        run_req = 1'b0;
        do_seq(3, 0);
        repeat (3) cyc();
    endtask

    initial begin
        test_reset();
        test_run();
        test_stop();
        test_overcurrent();
        test_timeout();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within 500000 time units");
        $fatal(1);
    end

endmodule
